// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: tracks the fetch PC, steers the IF/ID latch controls,
// drains an outstanding read after a redirect and counts instructions accepted by decode.
module fetch_ctrl #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imem_rdata,
   input  logic        stall_id,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   input  logic        pred_taken,
   input  logic [63:0] pred_target,
   input  logic        halt,
   output logic        imem_ren,
   output logic [63:0] imem_addr,
   output logic [63:0] pc_if,
   output logic [31:0] instr_if,
   output logic        pred_taken_if,
   output logic        flush,
   output logic        freeze,
   output logic        ihit_o,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q;
   logic [63:0] pc_q;
   logic [63:0] pending_pc_q;
   logic [31:0] cnt_q;

   logic [63:0] next_pc;
   logic [63:0] redirect_pc_al;
   logic        cnt_max;

   // Targets are word aligned; the low two address bits are dropped on load.
   always_comb begin
      redirect_pc_al = redirect_pc & ~64'd3;
      next_pc        = pred_taken ? (pred_target & ~64'd3) : (pc_q + 64'd4);
      cnt_max        = &cnt_q;
   end

   // Latch controls are combinational so the IF/ID latch sees them in the same cycle.
   always_comb begin
      imem_ren      = 1'b0;
      imem_addr     = pc_q;
      pc_if         = pc_q;
      instr_if      = 32'd0;
      pred_taken_if = 1'b0;
      flush         = 1'b0;
      freeze        = 1'b0;
      ihit_o        = 1'b0;
      if (!RST) begin
         unique case (state_q)
            FETCH: begin
               imem_ren      = 1'b1;
               instr_if      = imem_rdata;
               pred_taken_if = pred_taken;
               ihit_o        = ihit & ~halt;
               flush         = redirect & ~halt;
               freeze        = ihit & stall_id & ~redirect & ~halt;
            end
            DRAIN: begin
               imem_ren = 1'b1;
               flush    = redirect & ~halt;
            end
            HALTED: begin
               freeze = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign fetch_cnt = cnt_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         pending_pc_q <= 64'd0;
         cnt_q        <= 32'd0;
      end else begin
         case (state_q)
            FETCH: begin
               if (halt) begin
                  state_q <= HALTED;
               end else if (redirect) begin
                  if (ihit) begin
                     pc_q <= redirect_pc_al;
                  end else begin
                     // The read for the wrong path is still in flight; wait for it.
                     pending_pc_q <= redirect_pc_al;
                     state_q      <= DRAIN;
                  end
               end else if (ihit && !stall_id) begin
                  pc_q <= next_pc;
                  if (!cnt_max) begin
                     cnt_q <= cnt_q + 32'd1;
                  end
               end
            end
            DRAIN: begin
               if (halt) begin
                  state_q <= HALTED;
               end else if (redirect) begin
                  if (ihit) begin
                     pc_q    <= redirect_pc_al;
                     state_q <= FETCH;
                  end else begin
                     pending_pc_q <= redirect_pc_al;
                  end
               end else if (ihit) begin
                  pc_q    <= pending_pc_q;
                  state_q <= FETCH;
               end
            end
            HALTED: ;
            default: state_q <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change on the falling edge, outputs are sampled
// 1 time unit later, state updates land on the rising edge in between.
module tb_fetch_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] imem_rdata;
   logic        stall_id;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        pred_taken;
   logic [63:0] pred_target;
   logic        halt;
   logic        imem_ren;
   logic [63:0] imem_addr;
   logic [63:0] pc_if;
   logic [31:0] instr_if;
   logic        pred_taken_if;
   logic        flush;
   logic        freeze;
   logic        ihit_o;
   logic [31:0] fetch_cnt;

   int vectors = 0;
   int errors  = 0;

   always #5 CLK = ~CLK;

   fetch_ctrl #(.RESET_PC(64'h0)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .ihit          (ihit),
      .imem_rdata    (imem_rdata),
      .stall_id      (stall_id),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .halt          (halt),
      .imem_ren      (imem_ren),
      .imem_addr     (imem_addr),
      .pc_if         (pc_if),
      .instr_if      (instr_if),
      .pred_taken_if (pred_taken_if),
      .flush         (flush),
      .freeze        (freeze),
      .ihit_o        (ihit_o),
      .fetch_cnt     (fetch_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Move to the next falling edge, where new inputs are applied.
   task automatic nxt();
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b0; ihit = 1'b1; imem_rdata = 32'hAAAA_0000; stall_id = 1'b0;
      redirect = 1'b0; redirect_pc = 64'd0; pred_taken = 1'b0; pred_target = 64'd0;
      halt = 1'b0;
      #1 RST = 1'b1;
      #1;
      chk("rst_ren",    {63'd0, imem_ren}, 64'd0);
      chk("rst_flush",  {63'd0, flush},    64'd0);
      chk("rst_freeze", {63'd0, freeze},   64'd0);
      chk("rst_ihit_o", {63'd0, ihit_o},   64'd0);
      chk("rst_cnt",    {32'd0, fetch_cnt}, 64'd0);
      chk("rst_addr",   imem_addr,          64'h0);

      // Sequential fetch 0x0, 0x4, 0x8
      nxt(); RST = 1'b0; #1;
      chk("seq0_addr",   imem_addr,          64'h0);
      chk("seq0_ren",    {63'd0, imem_ren},  64'd1);
      chk("seq0_ihit_o", {63'd0, ihit_o},    64'd1);
      chk("seq0_instr",  {32'd0, instr_if},  64'hAAAA_0000);
      chk("seq0_pcif",   pc_if,              64'h0);
      nxt(); #1;
      chk("seq1_addr", imem_addr,           64'h4);
      chk("seq1_cnt",  {32'd0, fetch_cnt},  64'd1);
      nxt(); pred_taken = 1'b1; pred_target = 64'h103; #1;
      chk("seq2_addr",   imem_addr,              64'h8);
      chk("pred_ptif",   {63'd0, pred_taken_if}, 64'd1);

      // Taken prediction lands on the aligned target
      nxt(); pred_taken = 1'b0; pred_target = 64'd0;
      redirect = 1'b1; redirect_pc = 64'h12; #1;
      chk("pred_addr",    imem_addr,          64'h100);
      chk("seq_cnt3",     {32'd0, fetch_cnt}, 64'd3);
      chk("rdhit_flush",  {63'd0, flush},     64'd1);
      chk("rdhit_freeze", {63'd0, freeze},    64'd0);

      // Redirect with hit, then a two-cycle stall at 0x10
      nxt(); redirect = 1'b0; stall_id = 1'b1; #1;
      chk("rdhit_addr", imem_addr,          64'h10);
      chk("rdhit_cnt",  {32'd0, fetch_cnt}, 64'd3);
      chk("stall1_frz", {63'd0, freeze},    64'd1);
      chk("stall1_fl",  {63'd0, flush},     64'd0);
      nxt(); #1;
      chk("stall2_addr", imem_addr,       64'h10);
      chk("stall2_frz",  {63'd0, freeze}, 64'd1);
      nxt(); stall_id = 1'b0; #1;
      chk("stall_addr",  imem_addr,          64'h10);
      chk("stall_cnt",   {32'd0, fetch_cnt}, 64'd3);
      chk("unstall_frz", {63'd0, freeze},    64'd0);

      // Miss inserts a bubble
      nxt(); ihit = 1'b0; #1;
      chk("miss_addr",   imem_addr,          64'h14);
      chk("miss_cnt",    {32'd0, fetch_cnt}, 64'd4);
      chk("miss_ihit_o", {63'd0, ihit_o},    64'd0);
      chk("miss_frz",    {63'd0, freeze},    64'd0);
      chk("miss_ren",    {63'd0, imem_ren},  64'd1);

      // Redirect on a miss: flush once, drain the old read, then go to 0x200
      nxt(); redirect = 1'b1; redirect_pc = 64'h200; #1;
      chk("rdmiss_addr",  imem_addr,      64'h14);
      chk("rdmiss_flush", {63'd0, flush}, 64'd1);
      nxt(); redirect = 1'b0; #1;
      chk("drain1_flush", {63'd0, flush},    64'd0);
      chk("drain1_ren",   {63'd0, imem_ren}, 64'd1);
      chk("drain1_addr",  imem_addr,         64'h14);
      nxt(); #1;
      chk("drain2_addr", imem_addr, 64'h14);
      nxt(); ihit = 1'b1; #1;
      chk("drain3_ihit_o", {63'd0, ihit_o}, 64'd0);
      chk("drain3_addr",   imem_addr,       64'h14);

      // Second redirect while draining overwrites the pending target
      nxt(); ihit = 1'b0; redirect = 1'b1; redirect_pc = 64'h300; #1;
      chk("drained_addr", imem_addr,          64'h200);
      chk("drained_cnt",  {32'd0, fetch_cnt}, 64'd4);
      nxt(); redirect_pc = 64'h404; #1;
      chk("redrain_flush", {63'd0, flush},  64'd1);
      chk("redrain_frz",   {63'd0, freeze}, 64'd0);
      nxt(); redirect = 1'b0; ihit = 1'b1; #1;
      chk("redrain_addr",   imem_addr,       64'h200);
      chk("redrain_ihit_o", {63'd0, ihit_o}, 64'd0);
      nxt(); #1;
      chk("over_addr", imem_addr,          64'h404);
      chk("over_cnt",  {32'd0, fetch_cnt}, 64'd4);

      // Halt beats redirect and stall
      nxt(); halt = 1'b1; redirect = 1'b1; redirect_pc = 64'h500; stall_id = 1'b1; #1;
      chk("pre_halt_addr", imem_addr,          64'h408);
      chk("pre_halt_cnt",  {32'd0, fetch_cnt}, 64'd5);
      chk("halt_flush",    {63'd0, flush},     64'd0);
      nxt(); halt = 1'b0; stall_id = 1'b0; #1;
      chk("halted_ren",    {63'd0, imem_ren}, 64'd0);
      chk("halted_frz",    {63'd0, freeze},   64'd1);
      chk("halted_flush",  {63'd0, flush},    64'd0);
      chk("halted_ihit_o", {63'd0, ihit_o},   64'd0);
      nxt(); redirect = 1'b0; #1;
      chk("halted_cnt",  {32'd0, fetch_cnt}, 64'd5);
      chk("halted_ren2", {63'd0, imem_ren},  64'd0);
      chk("halted_addr", imem_addr,          64'h408);

      // Reset pulse leaves HALTED
      RST = 1'b1; #1;
      chk("rst2_addr", imem_addr,         64'h0);
      chk("rst2_ren",  {63'd0, imem_ren}, 64'd0);
      nxt(); RST = 1'b0; ihit = 1'b0; redirect = 1'b1; redirect_pc = 64'h600; #1;
      chk("rst2_run_addr", imem_addr,          64'h0);
      chk("rst2_run_ren",  {63'd0, imem_ren},  64'd1);
      chk("rst2_cnt",      {32'd0, fetch_cnt}, 64'd0);

      // Reset mid-DRAIN abandons the pending target
      nxt(); redirect = 1'b0; #1;
      chk("rstd_drain_ihit_o", {63'd0, ihit_o}, 64'd0);
      RST = 1'b1; #1;
      nxt(); RST = 1'b0; ihit = 1'b1; #1;
      chk("rstd_addr",   imem_addr,       64'h0);
      chk("rstd_ihit_o", {63'd0, ihit_o}, 64'd1);
      nxt(); redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; #1;
      chk("rstd_next_addr", imem_addr,          64'h4);
      chk("rstd_cnt",       {32'd0, fetch_cnt}, 64'd1);

      // PC wraps modulo 2^64 from the top aligned word
      nxt(); redirect = 1'b0; #1;
      chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      nxt(); #1;
      chk("wrap_addr", imem_addr,          64'h0);
      chk("wrap_cnt",  {32'd0, fetch_cnt}, 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
